mips32_mem_arbiter: RTL and testbench

- Shares the single-port unified instruction/data memory of the pipelined MIPS32 core between three requesters: IF-stage fetch, MEM-stage load/store, and a debug/loader port.
- Sequences the core through program load, run and post-halt readout.
- Issues at most one memory access per cycle, with registered return routing.
- Prevents fetch starvation under sustained data traffic.

---
 rtl/mips32_pkg.sv | 22 ++
 rtl/mips32_mem_arbiter_if.sv | 61 ++++++
 rtl/mips32_arb_sel.sv | 22 ++
 rtl/mips32_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mips32_mem_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips32_pkg.sv
// rtl/mips32_pkg.sv - shared types and defaults for the MIPS32 memory arbiter
// Purpose: core-sequencing states, return-path owner tags and default widths.
// Ports: none (package).
package mips32_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D,
    OWN_DBG
  } owner_t;

endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// rtl/mips32_mem_arbiter_if.sv - requester, memory and core-control bundle for the arbiter
// Purpose: groups fetch, data, debug, memory and run-control signals.
// Ports: slave = arbiter side, master = requesters/memory/core side.
interface mips32_mem_arbiter_if
  import mips32_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt;
  logic          dbg_rvalid;

  logic          dbg_start;
  logic          halted;
  logic [DW-1:0] rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          core_run;
  logic          pc_clr;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_start, halted, mem_rdata,
    output if_gnt, if_rvalid, d_gnt, d_rvalid, dbg_gnt, dbg_rvalid,
    output rdata, mem_en, mem_we, mem_addr, mem_wdata, core_run, pc_clr
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_start, halted, mem_rdata,
    input  if_gnt, if_rvalid, d_gnt, d_rvalid, dbg_gnt, dbg_rvalid,
    input  rdata, mem_en, mem_we, mem_addr, mem_wdata, core_run, pc_clr
  );

endinterface

// File: rtl/mips32_arb_sel.sv
// rtl/mips32_arb_sel.sv - combinational priority selector with fetch-starvation override
// Purpose: one-hot grant from eligibility-qualified requests; dbg > d > if,
//          except fetch beats data while starved. Debug always wins.
// Ports: if_req/d_req/dbg_req (already qualified by state), starved in;
//        if_gnt/d_gnt/dbg_gnt out.
module mips32_arb_sel (
  input  logic if_req,
  input  logic d_req,
  input  logic dbg_req,
  input  logic starved,
  output logic if_gnt,
  output logic d_gnt,
  output logic dbg_gnt
);

  always_comb begin
    dbg_gnt = dbg_req;
    d_gnt   = !dbg_req && d_req && !(starved && if_req);
    if_gnt  = !dbg_req && if_req && (!d_req || starved);
  end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// rtl/mips32_mem_arbiter.sv - single-port memory arbiter and run sequencer for the MIPS32 core
// Purpose: sequences LOAD -> RUN -> DONE, grants one memory access per cycle
//          to fetch, data or debug, and routes read data back one cycle later.
// Ports: clk, rst_n (sync active-low); bus (slave modport) carries requester
//        handshakes, the memory port and core_run/pc_clr control.
module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  mips32_mem_arbiter_if.slave bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  state_t        state;
  state_t        state_nxt;
  logic          pc_clr_q;
  logic [CW-1:0] starve_cnt;
  owner_t        owner_q;

  logic          if_ok;
  logic          d_ok;
  logic          starved;
  logic          g_if;
  logic          g_d;
  logic          g_dbg;

  // Next state and per-state eligibility.
  always_comb begin
    state_nxt = state;
    if_ok     = 1'b0;
    d_ok      = 1'b0;
    case (state)
      ST_LOAD: begin
        if (bus.dbg_start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if_ok = 1'b1;
        d_ok  = 1'b1;
        // halted takes precedence; dbg_start is ignored while running
        if (bus.halted) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        // data stays eligible so stores issued before the halt drain
        d_ok = 1'b1;
        if (bus.dbg_start) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  assign starved = (starve_cnt == CW'(STARVE_LIMIT));

  mips32_arb_sel u_sel (
    .if_req  (bus.if_req && if_ok),
    .d_req   (bus.d_req && d_ok),
    .dbg_req (bus.dbg_req),
    .starved (starved),
    .if_gnt  (g_if),
    .d_gnt   (g_d),
    .dbg_gnt (g_dbg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_LOAD;
      pc_clr_q   <= 1'b0;
      starve_cnt <= '0;
      owner_q    <= OWN_NONE;
    end else begin
      state    <= state_nxt;
      // pulse covers exactly the first RUN cycle after a (re)start
      pc_clr_q <= (state != ST_RUN) && (state_nxt == ST_RUN);

      if (g_if || !bus.if_req || !if_ok)
        starve_cnt <= '0;
      else if (g_d && !starved)
        starve_cnt <= starve_cnt + CW'(1);

      // tag only reads; writes complete in their grant cycle
      if (g_dbg && !bus.dbg_we)  owner_q <= OWN_DBG;
      else if (g_d && !bus.d_we) owner_q <= OWN_D;
      else if (g_if)             owner_q <= OWN_IF;
      else                       owner_q <= OWN_NONE;
    end
  end

  // Memory drive muxed from the winner; idle bus is all zeros.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (g_dbg) begin
      bus.mem_we    = bus.dbg_we;
      bus.mem_addr  = bus.dbg_addr;
      bus.mem_wdata = bus.dbg_wdata;
    end else if (g_d) begin
      bus.mem_we    = bus.d_we;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end else if (g_if) begin
      bus.mem_addr  = bus.if_addr;
    end
  end

  assign bus.mem_en     = g_if || g_d || g_dbg;
  assign bus.if_gnt     = g_if;
  assign bus.d_gnt      = g_d;
  assign bus.dbg_gnt    = g_dbg;
  assign bus.if_rvalid  = (owner_q == OWN_IF);
  assign bus.d_rvalid   = (owner_q == OWN_D);
  assign bus.dbg_rvalid = (owner_q == OWN_DBG);
  assign bus.rdata      = bus.mem_rdata;
  assign bus.core_run   = (state == ST_RUN);
  assign bus.pc_clr     = pc_clr_q;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// tb/tb_mips32_mem_arbiter.sv - self-checking bench for mips32_mem_arbiter
module tb_mips32_mem_arbiter;
  import mips32_pkg::*;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips32_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mips32_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] sram [0:1023];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= sram[bus.mem_addr];
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: mode 0=loading 1=running 2=done; pend 0=none 1=fetch 2=data 3=debug
  int            mode = 0;
  int            cnt = 0;
  int            pend = 0;
  logic [31:0]   pend_data = '0;
  bit            exp_pc_clr = 1'b0;
  logic [31:0]   ref_mem [0:1023];

  bit            obs_if_gnt, obs_d_gnt, obs_dbg_gnt, obs_pc_clr, obs_core_run;
  bit            obs_if_rv, obs_d_rv, obs_dbg_rv;
  logic [31:0]   obs_rdata;

  task automatic step();
    bit e_if, e_d, e_dbg, if_ok, d_ok, starved, e_we;
    logic [31:0] e_addr, e_wdata;
    int nmode;
    @(negedge clk);
    if_ok   = (mode == 1);
    d_ok    = (mode != 0);
    starved = (cnt == LIM);
    e_dbg   = bus.dbg_req;
    e_d     = !e_dbg && bus.d_req && d_ok && !(bus.if_req && if_ok && starved);
    e_if    = !e_dbg && bus.if_req && if_ok && !e_d;
    e_we = 1'b0; e_addr = '0; e_wdata = '0;
    if (e_dbg)     begin e_we = bus.dbg_we; e_addr = 32'(bus.dbg_addr); e_wdata = bus.dbg_wdata; end
    else if (e_d)  begin e_we = bus.d_we;   e_addr = 32'(bus.d_addr);   e_wdata = bus.d_wdata;   end
    else if (e_if) begin e_addr = 32'(bus.if_addr); end

    obs_if_gnt = bus.if_gnt; obs_d_gnt = bus.d_gnt; obs_dbg_gnt = bus.dbg_gnt;
    obs_pc_clr = bus.pc_clr; obs_core_run = bus.core_run;
    obs_if_rv = bus.if_rvalid; obs_d_rv = bus.d_rvalid; obs_dbg_rv = bus.dbg_rvalid;
    obs_rdata = bus.rdata;

    check("if_gnt", 32'(bus.if_gnt), 32'(e_if));
    check("d_gnt", 32'(bus.d_gnt), 32'(e_d));
    check("dbg_gnt", 32'(bus.dbg_gnt), 32'(e_dbg));
    check("mem_en", 32'(bus.mem_en), 32'(e_if || e_d || e_dbg));
    check("mem_we", 32'(bus.mem_we), 32'(e_we));
    check("mem_addr", 32'(bus.mem_addr), e_addr);
    check("mem_wdata", bus.mem_wdata, e_wdata);
    check("core_run", 32'(bus.core_run), 32'(mode == 1));
    check("pc_clr", 32'(bus.pc_clr), 32'(exp_pc_clr));
    check("if_rvalid", 32'(bus.if_rvalid), 32'(pend == 1));
    check("d_rvalid", 32'(bus.d_rvalid), 32'(pend == 2));
    check("dbg_rvalid", 32'(bus.dbg_rvalid), 32'(pend == 3));
    if (pend != 0) check("rdata", bus.rdata, pend_data);

    @(posedge clk);
    // memory side effects of this cycle's grant happen even during reset
    pend = 0;
    if ((e_if || e_d || e_dbg) && !e_we) begin
      pend      = e_dbg ? 3 : (e_d ? 2 : 1);
      pend_data = ref_mem[e_addr[9:0]];
    end
    if (e_we) ref_mem[e_addr[9:0]] = e_wdata;

    if (!rst_n) begin
      mode = 0; cnt = 0; pend = 0; exp_pc_clr = 1'b0;
    end else begin
      nmode = mode;
      if (mode == 0 && bus.dbg_start) nmode = 1;
      else if (mode == 1 && bus.halted) nmode = 2;
      else if (mode == 2 && bus.dbg_start) nmode = 1;
      exp_pc_clr = (mode != 1) && (nmode == 1);
      if (bus.if_req && if_ok && e_d) cnt = (cnt + 1 > LIM) ? LIM : cnt + 1;
      else if (e_if || !bus.if_req || mode != 1) cnt = 0;
      mode = nmode;
    end
    #1;
  endtask

  logic [31:0] prog [0:7];
  int          n_dbg_g;
  int          n_if_g;
  logic [31:0] if_hist;

  initial begin
    for (int i = 0; i < 1024; i++) begin sram[i] = '0; ref_mem[i] = '0; end
    prog[0] = 32'h28010078; prog[1] = 32'h8c220000; prog[2] = 32'h2043002d;
    prog[3] = 32'h00431822; prog[4] = 32'hac230001; prog[5] = 32'h00000000;
    prog[6] = 32'hfc000000; prog[7] = 32'h00000000;
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    bus.dbg_start = 0; bus.halted = 0;

    rst_n = 0;
    repeat (2) step();
    rst_n = 1;

    // program load with fetch knocking the whole time
    bus.if_req = 1; bus.if_addr = '0;
    n_dbg_g = 0; n_if_g = 0;
    for (int i = 0; i < 9; i++) begin
      bus.dbg_req = 1; bus.dbg_we = 1;
      bus.dbg_addr  = (i < 8) ? AW'(i) : AW'(120);
      bus.dbg_wdata = (i < 8) ? prog[i] : 32'd85;
      step();
      n_dbg_g += int'(obs_dbg_gnt);
      n_if_g  += int'(obs_if_gnt);
    end
    bus.dbg_req = 0; bus.dbg_we = 0;
    check("load_dbg_gnt_count", 32'(n_dbg_g), 32'd9);
    check("load_if_gnt_count", 32'(n_if_g), 32'd0);

    // start: first RUN cycle carries pc_clr and the fetch of address 0
    bus.dbg_start = 1; step(); bus.dbg_start = 0;
    step();
    check("start_pc_clr", 32'(obs_pc_clr), 32'd1);
    check("start_fetch_gnt", 32'(obs_if_gnt), 32'd1);
    bus.if_req = 0;
    step();
    check("fetch_rvalid", 32'(obs_if_rv), 32'd1);
    check("fetch_rdata", obs_rdata, 32'h28010078);

    // sustained data vs fetch: fetch wins every fifth cycle
    bus.if_req = 1; bus.if_addr = AW'(1);
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = AW'(2);
    if_hist = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      if_hist[i] = obs_if_gnt;
    end
    check("starve_pattern", if_hist, 32'h0000_0210);

    // debug outranks everything
    bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = AW'(120);
    step();
    check("dbg_only_gnt", {29'd0, obs_dbg_gnt, obs_d_gnt, obs_if_gnt}, 32'd4);
    bus.dbg_req = 0;
    step();
    check("dbg_rvalid", 32'(obs_dbg_rv), 32'd1);
    check("dbg_rdata", obs_rdata, 32'd85);

    // halt with a store outstanding; the store still lands
    bus.halted = 1;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = AW'(121); bus.d_wdata = 32'd40;
    step();
    check("halt_store_gnt", 32'(obs_d_gnt), 32'd1);
    bus.d_req = 0; bus.d_we = 0;
    step();
    check("done_if_ignored", 32'(obs_if_gnt), 32'd0);
    check("done_core_run", 32'(obs_core_run), 32'd0);
    bus.dbg_req = 1; bus.dbg_addr = AW'(121);
    step();
    bus.dbg_req = 0;
    step();
    check("readout_rdata", obs_rdata, 32'd40);

    // reset right after a read grant drops the return
    bus.dbg_req = 1; bus.dbg_addr = AW'(5);
    step();
    bus.dbg_req = 0; bus.if_req = 0; bus.halted = 0;
    rst_n = 0;
    step();
    rst_n = 1;
    step();
    check("reset_drops_rvalid", {29'd0, obs_if_rv, obs_d_rv, obs_dbg_rv}, 32'd0);
    check("reset_core_run", 32'(obs_core_run), 32'd0);

    // randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      rst_n         = ($urandom_range(0, 99) != 0);
      bus.if_req    = $urandom_range(0, 1) == 1;
      bus.if_addr   = AW'($urandom_range(0, 15));
      bus.d_req     = $urandom_range(0, 1) == 1;
      bus.d_we      = $urandom_range(0, 1) == 1;
      bus.d_addr    = AW'($urandom_range(0, 15));
      bus.d_wdata   = $urandom;
      bus.dbg_req   = $urandom_range(0, 3) == 0;
      bus.dbg_we    = $urandom_range(0, 1) == 1;
      bus.dbg_addr  = AW'($urandom_range(0, 15));
      bus.dbg_wdata = $urandom;
      bus.dbg_start = $urandom_range(0, 19) == 0;
      bus.halted    = $urandom_range(0, 19) == 0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
